fft_int2fp_converter: RTL and testbench
=======================================

// Module: fft_int2fp_converter
// PURPOSE
//  Input-side counterpart of the FFT output fp2int stage: converts 4 complex lanes of signed
//  int32 samples ({imag[63:32], real[31:0]} per lane) into IEEE-754 single-precision, ready for the FFT core.
//  3-stage pipeline with valid/ready flow control; tags the last beat of each FFT frame.
// PARAMETERS
//  FFT_LEN      256   points per FFT frame; multiple of 4, >= 8
//  FRAME_BEATS  FFT_LEN/4 (localparam)   beats per frame, 4 samples per beat
// PORTS
//  s_axi_aclk     in   1   clock; all logic on rising edge
//  s_axi_areset   in   1   reset, synchronous, active-high
//  in_valid       in   1   input beat valid
//  in_ready       out  1   converter can accept a beat
//  data_0..3      in   64  int32 lane pairs {imag, real}
//  out_valid      out  1   output beat valid
//  out_ready      in   1   downstream accepts the beat
//  result_0..3    out  64  fp32 lane pairs {imag, real}, same lane order as the inputs
//  out_last       out  1   beat FRAME_BEATS-1 of the current frame
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, result_*=0, all stage valids=0, beat_cnt=0. in_ready=1 after reset.
//  - Global enable en = !out_valid | out_ready; in_ready = en. The pipeline holds on stall, so no data is lost.
//  - Input accepted when in_valid & in_ready. Latency is exactly 3 cycles with no stall.
//    Throughput is 1 beat per cycle.
//  - Stage valids shift on en; bubbles propagate. No bubble collapsing.
//  - Stage 1: sign = x[31]; mag = sign ? -x : x, as 32-bit unsigned. -2^31 gives mag = 0x80000000.
//  - Stage 2: lz = leading-zero count of mag (0..31); norm = mag << lz; zero flag = (mag == 0).
//  - Stage 3: mant = norm[30:8]; guard = norm[7]; sticky = |norm[6:0]; exp = 158 - lz.
//    Round (see CONFIGURATION). If the mantissa carries out, mant = 0 and exp = exp + 1.
//    Pack {sign, exp[7:0], mant}. Zero input gives 0x00000000; -0 is never produced.
//  - All 8 words (4 lanes x real/imag) are converted independently and identically.
//  - out_last = (beat_cnt == FRAME_BEATS-1) & out_valid.
//    beat_cnt increments on the output handshake (out_valid & out_ready).
//    It wraps to 0 after FRAME_BEATS-1.
//  - Held output: result_*, out_last and out_valid stay stable while out_valid & !out_ready.
//  - Reset mid-frame: the pipeline is flushed, beat_cnt = 0, and the next accepted beat starts a new frame.
// CONFIGURATION
//  FFT_INT2FP_RNE_EN defined:
//    round to nearest, ties to even: inc = guard & (sticky | mant[0]).
//  FFT_INT2FP_RNE_EN undefined:
//    truncate toward zero: inc = 0. The guard/sticky logic is removed.
//  Latency is 3 in both builds.
// STRUCTURE
//  Shared package fft_pkg:
//    FP32_BIAS = 127, FP32_W = 32, CPLX_W = 64, FFT_LANES = 4
//    function clz32 for the leading-zero count
//  Sub-module fft_int2fp_unit:
//    one 32-bit, 3-stage datapath with an en input, no valid tracking
//    instantiated 8 times (lanes 0..3, real and imag)
//  Top level holds the stage valids, the en/ready logic and beat_cnt.
// TESTING
//  1. real 1 / imag -1 on lane 0 -> result_0 = {0xBF800000, 0x3F800000}, out_valid exactly 3 cycles after accept.
//  2. Inputs 0, 100, -2^31 on lanes 1..3 -> 0x00000000, 0x42C80000, 0xCF000000.
//  3. Inputs 2^31-1 and 16777219:
//     RNE build      -> 0x4F000000 and 0x4B800002
//     truncate build -> 0x4EFFFFFF and 0x4B800001
//  4. Stream 64 beats with FFT_LEN=256 and out_ready toggling randomly 50%:
//     all beats arrive in order and unchanged; out_last is set only on the 64th output beat;
//     in_ready = 0 exactly when out_valid & !out_ready.
//  5. Hold out_ready=0 for 10 cycles with the pipeline full -> outputs stable, no beat accepted or dropped.
//     Release -> 3 beats drain back-to-back.
//  6. Assert s_axi_areset after 20 beats of a frame -> out_valid = 0 next cycle.
//     The next frame's out_last falls on its 64th beat.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT front-end int32 -> fp32 conversion.
package fft_pkg;

  localparam int FP32_BIAS = 127;
  localparam int FP32_W    = 32;
  localparam int CPLX_W    = 64;
  localparam int FFT_LANES = 4;

  // Leading-zero count; result for v == 0 is don't-care (callers track zero separately).
  function automatic logic [4:0] clz32(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fft_int2fp_unit.sv
// One 32-bit signed int -> fp32 datapath, 3 register stages advanced by en_i.
// FFT_INT2FP_RNE_EN selects round-to-nearest-even; otherwise truncation toward zero.
module fft_int2fp_unit
  import fft_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

`ifdef FFT_INT2FP_RNE_EN
  localparam int FRAC_LO = 0;
`else
  localparam int FRAC_LO = 8;
`endif

  logic        s1_sign_q, s1_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic        s2_sign_q, s2_zero_q;
  logic [4:0]  s2_lz_q, s2_lz_d;
  logic [30:FRAC_LO] s2_frac_q, s2_frac_d;
  logic [31:0] y_q, y_d;

  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;
  logic        inc;

  always_comb begin
    s1_sign_d = x_i[31];
    s1_mag_d  = x_i[31] ? (~x_i + 32'd1) : x_i;
    s2_lz_d   = clz32(s1_mag_q);
    // The implicit leading one (bit 31 of the normalised value) is dropped here.
    s2_frac_d = (31 - FRAC_LO)'((s1_mag_q << s2_lz_d) >> FRAC_LO);
  end

  always_comb begin
    mant = s2_frac_q[30:8];
`ifdef FFT_INT2FP_RNE_EN
    inc  = s2_frac_q[7] & ((|s2_frac_q[6:0]) | mant[0]);
`else
    inc  = 1'b0;
`endif
    mant_r = {1'b0, mant} + {23'd0, inc};
    exp_r  = 8'(FP32_BIAS + 31) - {3'd0, s2_lz_q} + {7'd0, mant_r[23]};
    y_d    = s2_zero_q ? 32'd0 : {s2_sign_q, exp_r, mant_r[22:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b1;
      s2_lz_q   <= '0;
      s2_frac_q <= '0;
      y_q       <= '0;
    end else if (en_i) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= (s1_mag_q == 32'd0);
      s2_lz_q   <= s2_lz_d;
      s2_frac_q <= s2_frac_d;
      y_q       <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/fft_int2fp_converter.sv
// 4-lane complex int32 -> fp32 converter, 3-cycle pipeline, valid/ready, frame last tagging.
// Rounding mode set by FFT_INT2FP_RNE_EN (defined: RNE, undefined: truncate).
module fft_int2fp_converter
  import fft_pkg::*;
#(
  parameter int FFT_LEN = 256
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CPLX_W-1:0] data_0,
  input  logic [CPLX_W-1:0] data_1,
  input  logic [CPLX_W-1:0] data_2,
  input  logic [CPLX_W-1:0] data_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CPLX_W-1:0] result_0,
  output logic [CPLX_W-1:0] result_1,
  output logic [CPLX_W-1:0] result_2,
  output logic [CPLX_W-1:0] result_3,
  output logic              out_last
);

  localparam int FRAME_BEATS = FFT_LEN / 4;
  localparam int CNT_W       = $clog2(FRAME_BEATS);

  logic              en;
  logic              v1_q, v2_q, out_valid_q;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CPLX_W-1:0] din  [FFT_LANES];
  logic [CPLX_W-1:0] dout [FFT_LANES];

  assign din[0] = data_0;
  assign din[1] = data_1;
  assign din[2] = data_2;
  assign din[3] = data_3;

  // Whole pipeline freezes only when the output register is full and not being taken.
  assign en = !out_valid_q || out_ready;

  for (genvar l = 0; l < FFT_LANES; l++) begin : g_lane
    for (genvar p = 0; p < 2; p++) begin : g_part
      fft_int2fp_unit u_unit (
        .clk_i (s_axi_aclk),
        .rst_i (s_axi_areset),
        .en_i  (en),
        .x_i   (din[l][p*FP32_W +: FP32_W]),
        .y_o   (dout[l][p*FP32_W +: FP32_W])
      );
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_valid_q && out_ready) begin
      beat_cnt_d = (beat_cnt_q == CNT_W'(FRAME_BEATS - 1)) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (en) begin
        v1_q        <= in_valid;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (beat_cnt_q == CNT_W'(FRAME_BEATS - 1));
  assign result_0  = dout[0];
  assign result_1  = dout[1];
  assign result_2  = dout[2];
  assign result_3  = dout[3];

endmodule

// File: tb/tb_fft_int2fp_converter.sv
// Randomised scoreboard bench for fft_int2fp_converter against an arithmetic fp32 model.
module tb_fft_int2fp_converter;

  localparam int FFT_LEN     = 256;
  localparam int FRAME_BEATS = FFT_LEN / 4;
`ifdef FFT_INT2FP_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_areset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [63:0] data_0, data_1, data_2, data_3;
  logic [63:0] result_0, result_1, result_2, result_3;

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_q[$];
  int           out_cnt = 0;
  int           acc_cnt = 0;
  bit           hold_prev = 0;
  logic [255:0] held;
  logic         held_last;

  always #5 s_axi_aclk = ~s_axi_aclk;

  fft_int2fp_converter #(.FFT_LEN(FFT_LEN)) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_areset (s_axi_areset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_0       (data_0),
    .data_1       (data_1),
    .data_2       (data_2),
    .data_3       (data_3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_0     (result_0),
    .result_1     (result_1),
    .result_2     (result_2),
    .result_3     (result_3),
    .out_last     (out_last)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference conversion: exact magnitude, find exponent, round the discarded remainder.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint m, q, rem, half;
    int     e, sh;
    logic   s;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? -longint'($signed(x)) : longint'(x);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (RNE && (rem > half || (rem == half && q[0]))) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [255:0] ref_beat(input logic [255:0] d);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = ref_fp(d[w*32 +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'h7fff_ffff;
      3:       return 32'($urandom % 256);
      4:       return -32'($urandom % 100000);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [255:0] res_cat();
    return {result_3, result_2, result_1, result_0};
  endfunction

  task automatic drive_data(input logic [255:0] d);
    data_0 = d[63:0];
    data_1 = d[127:64];
    data_2 = d[191:128];
    data_3 = d[255:192];
  endtask

  task automatic step(input bit iv, input bit ordy);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = rand_word();
    in_valid  = iv;
    out_ready = ordy;
    drive_data(d);
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (hold_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", res_cat(), held);
      check("hold_last", out_last, held_last);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        check("data", res_cat(), exp_q.pop_front());
        check("last", out_last, (out_cnt % FRAME_BEATS) == FRAME_BEATS - 1);
        out_cnt++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_beat(d));
      acc_cnt++;
    end
    hold_prev = out_valid && !out_ready;
    held      = res_cat();
    held_last = out_last;
    @(posedge s_axi_aclk); #1;
  endtask

  task automatic do_reset();
    s_axi_areset = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    s_axi_areset = 1'b0;
    exp_q.delete();
    out_cnt   = 0;
    hold_prev = 0;
  endtask

  task automatic stream(input int beats);
    int target, guard;
    target = acc_cnt + beats;
    guard  = 0;
    while (acc_cnt < target && guard < 2000) begin
      step(1'b1, 1'($urandom % 2));
      guard++;
    end
    check("stream_timeout", 256'(acc_cnt), 256'(target));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check("drain_timeout", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic directed(input string tag, input logic [255:0] d, input logic [255:0] want);
    int lat;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_data(d);
    @(posedge s_axi_aclk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge s_axi_aclk); #1;
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), 256'd3);
    check(tag, res_cat(), want);
    @(posedge s_axi_aclk); #1;
  endtask

  initial begin
    int a0, o0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive_data('0);
    do_reset();

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_result", res_cat(), 256'd0);
    check("rst_in_ready", in_ready, 1'b1);

    directed("one_minus_one", {192'd0, 32'hffff_ffff, 32'd1},
             {192'd0, 32'hbf80_0000, 32'h3f80_0000});
    directed("zero_100_min",
             {32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100, 64'd0, 64'd0},
             {32'hcf00_0000, 32'hcf00_0000, 32'h42c8_0000, 32'h42c8_0000, 128'd0});
`ifdef FFT_INT2FP_RNE_EN
    directed("rounding", {192'd0, 32'd16777219, 32'h7fff_ffff},
             {192'd0, 32'h4b80_0002, 32'h4f00_0000});
`else
    directed("rounding", {192'd0, 32'd16777219, 32'h7fff_ffff},
             {192'd0, 32'h4b80_0001, 32'h4eff_ffff});
`endif

    // Full frame under random backpressure.
    do_reset();
    stream(FRAME_BEATS);
    drain();
    check("frame_out_count", 256'(out_cnt), 256'(FRAME_BEATS));

    // Stall with a full pipeline, then release.
    a0 = acc_cnt;
    repeat (10) step(1'b1, 1'b0);
    check("stall_accepts", 256'(acc_cnt - a0), 256'd3);
    o0 = out_cnt;
    repeat (3) step(1'b0, 1'b1);
    check("drain_back_to_back", 256'(out_cnt - o0), 256'd3);
    check("drain_empty", out_valid, 1'b0);

    // Reset in the middle of a frame.
    do_reset();
    while (out_cnt < 20 && acc_cnt < 100000) step(1'b1, 1'($urandom % 2));
    s_axi_areset = 1'b1;
    in_valid     = 1'b0;
    @(posedge s_axi_aclk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_last", out_last, 1'b0);
    s_axi_areset = 1'b0;
    exp_q.delete();
    out_cnt   = 0;
    hold_prev = 0;
    stream(FRAME_BEATS);
    drain();
    check("post_rst_frame_count", 256'(out_cnt), 256'(FRAME_BEATS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
